// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: state encoding,
// shift width and the largest supported iteration count.
package cordic_pkg;

   localparam int SHIFT_W  = 4;
   localparam int MAX_ITER = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SHX  = 3'd2,
      ST_SHY  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/cordic_iter_seq.sv
// Two-cycle-per-iteration sequencer sharing one barrel shifter between X and Y.
// start seen at edge 0 gives ld_init in cycle 1 and a done pulse in cycle 2+2*NUM_ITER.
module cordic_iter_seq
   import cordic_pkg::*;
#(
   parameter int NUM_ITER = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               abort,
   input  logic               z_sign,
   input  logic               y_sign,
   output logic               ready,
   output logic               done,
   output logic               ld_init,
   output logic               sh_sel,
   output logic [SHIFT_W-1:0] shift_amt,
   output logic [SHIFT_W-1:0] atan_addr,
   output logic               tmp_en,
   output logic               xyz_en,
   output logic               dir
);

   if (NUM_ITER < 1 || NUM_ITER > MAX_ITER) begin : g_bad_num_iter
      $error("cordic_iter_seq: NUM_ITER must be within 1..MAX_ITER");
   end

   localparam logic [SHIFT_W-1:0] LAST_I = SHIFT_W'(NUM_ITER - 1);

   state_t             state_q, state_d;
   logic [SHIFT_W-1:0] i_q, i_d;
   logic               mode_q, mode_d;
   logic               dir_q, dir_d;
   logic               ready_q, done_q, ld_init_q, sh_sel_q, tmp_en_q, xyz_en_q;

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = mode;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            i_d     = '0;
            state_d = ST_SHX;
         end
         ST_SHX: begin
            // Direction is frozen here so it stays stable across the whole SHY update.
            dir_d   = mode_q ? y_sign : ~z_sign;
            state_d = ST_SHY;
         end
         ST_SHY: begin
            if (i_q == LAST_I) begin
               state_d = ST_DONE;
            end else begin
               i_d     = i_q + SHIFT_W'(1);
               state_d = ST_SHX;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         i_d     = i_q;
         mode_d  = mode_q;
         dir_d   = dir_q;
      end
   end

   // Moore outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         i_q       <= '0;
         mode_q    <= 1'b0;
         dir_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         ld_init_q <= 1'b0;
         sh_sel_q  <= 1'b0;
         tmp_en_q  <= 1'b0;
         xyz_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         ready_q   <= (state_d == ST_IDLE);
         done_q    <= (state_d == ST_DONE);
         ld_init_q <= (state_d == ST_LOAD);
         sh_sel_q  <= (state_d == ST_SHY);
         tmp_en_q  <= (state_d == ST_SHX);
         xyz_en_q  <= (state_d == ST_SHY);
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign ld_init   = ld_init_q;
   assign sh_sel    = sh_sel_q;
   assign tmp_en    = tmp_en_q;
   assign xyz_en    = xyz_en_q;
   assign dir       = dir_q;
   assign shift_amt = i_q;
   assign atan_addr = i_q;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Bench for cordic_iter_seq: scoreboard of expected ld_init/xyz_en/done events
// for a 16-iteration instance plus a vector table run on a 1-iteration instance.
module tb_cordic_iter_seq;

   localparam int NI = 16;

   logic       clk = 1'b0;
   logic       reset, start, start1, mode, abort, z_sign, y_sign;
   logic       ready, done, ld_init, sh_sel, tmp_en, xyz_en, dir;
   logic [3:0] shift_amt, atan_addr;
   logic       ready1, done1, ld_init1, sh_sel1, tmp_en1, xyz_en1, dir1;
   logic [3:0] shift_amt1, atan_addr1;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int base = 0;
   int done_cnt = 0;
   bit sb_on = 1'b0;

   typedef struct {
      int   cyc;
      int   kind;
      int   sh;
      logic dir;
   } ev_t;
   ev_t sbq[$];
   ev_t mon_e;
   int  mon_kind;

   typedef struct packed {
      logic m;
      logic z;
      logic y;
      logic d;
   } vec_t;
   vec_t tbl[8];
   logic [5:0] seq1[1:5];

   cordic_iter_seq #(.NUM_ITER(NI)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
      .z_sign(z_sign), .y_sign(y_sign), .ready(ready), .done(done),
      .ld_init(ld_init), .sh_sel(sh_sel), .shift_amt(shift_amt),
      .atan_addr(atan_addr), .tmp_en(tmp_en), .xyz_en(xyz_en), .dir(dir)
   );

   cordic_iter_seq #(.NUM_ITER(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .mode(mode), .abort(abort),
      .z_sign(z_sign), .y_sign(y_sign), .ready(ready1), .done(done1),
      .ld_init(ld_init1), .sh_sel(sh_sel1), .shift_amt(shift_amt1),
      .atan_addr(atan_addr1), .tmp_en(tmp_en1), .xyz_en(xyz_en1), .dir(dir1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Event kinds: 0 = ld_init, 1 = xyz_en (carries shift and dir), 2 = done.
   always @(negedge clk) begin
      if (sb_on && (ld_init || xyz_en || done)) begin
         mon_kind = ld_init ? 0 : (xyz_en ? 1 : 2);
         if (done) done_cnt++;
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind %0d at cycle %0d, want no event", mon_kind, cyc);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_kind != mon_e.kind || cyc != mon_e.cyc ||
                (mon_kind == 1 && (32'(shift_amt) !== mon_e.sh || dir !== mon_e.dir))) begin
               bad++;
               $display("FAIL sb_event: got kind %0d cyc %0d sh %0d dir %b, want kind %0d cyc %0d sh %0d dir %b",
                        mon_kind, cyc, shift_amt, dir, mon_e.kind, mon_e.cyc, mon_e.sh, mon_e.dir);
            end
         end
      end
   end

   task automatic wait_cyc(input int t);
      int n = 0;
      while (cyc != t && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (cyc != t) begin
         total++;
         bad++;
         $display("FAIL wait_cyc: got cycle %0d, want %0d", cyc, t);
      end
   endtask

   task automatic push_op(input int b, input int nx, input logic [15:0] dirs, input bit wd);
      ev_t e;
      e = '{b + 1, 0, 0, 1'b0};
      sbq.push_back(e);
      for (int j = 0; j < nx; j++) begin
         e = '{b + 3 + 2 * j, 1, j, dirs[j]};
         sbq.push_back(e);
      end
      if (wd) begin
         e = '{b + 2 + 2 * NI, 2, 0, 1'b0};
         sbq.push_back(e);
      end
   endtask

   task automatic run_op(input logic m, input int nx, input logic [15:0] dirs, input bit wd);
      mode  = m;
      start = 1'b1;
      base  = cyc;
      push_op(base, nx, dirs, wd);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
      chk(nm, sbq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
      // {ready, ld_init, sh_sel, tmp_en, xyz_en, done} for cycles 1..5 of a one-iteration run
      seq1[1] = 6'b010000;
      seq1[2] = 6'b000100;
      seq1[3] = 6'b001010;
      seq1[4] = 6'b000001;
      seq1[5] = 6'b100000;

      reset = 1'b1; start = 1'b0; start1 = 1'b0; mode = 1'b0;
      abort = 1'b0; z_sign = 1'b0; y_sign = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {ready, ld_init, sh_sel, tmp_en, xyz_en, done, dir, shift_amt, atan_addr},
          {1'b1, 14'b0});
      chk("reset_outs1", {ready1, ld_init1, xyz_en1, done1, dir1, shift_amt1}, {1'b1, 8'b0});
      reset = 1'b0;
      sb_on = 1'b1;
      @(negedge clk);

      // Reset asserted in the SHY cycle of iteration 1.
      run_op(1'b0, 2, 16'hFFFF, 1'b0);
      wait_cyc(base + 5);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_shy", {ready, xyz_en, done, dir, shift_amt}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      reset = 1'b0;
      drain("rst_mid_sb");

      // Full rotation run: shift held two cycles per iteration.
      d0 = done_cnt;
      run_op(1'b0, NI, 16'hFFFF, 1'b1);
      for (int k = 2; k <= 33; k++) begin
         wait_cyc(base + k);
         chk($sformatf("rot_shift_k%0d", k), {shift_amt, atan_addr, tmp_en, sh_sel},
             {4'((k - 2) / 2), 4'((k - 2) / 2), 1'(k % 2 == 0), 1'(k % 2 == 1)});
      end
      drain("rot_sb");
      chk("rot_done_cnt", done_cnt - d0, 1);

      // start pulsed while busy is dropped.
      d0 = done_cnt;
      run_op(1'b0, NI, 16'hFFFF, 1'b1);
      wait_cyc(base + 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("busy_start_sb");
      chk("busy_done_cnt", done_cnt - d0, 1);

      // start held high: back-to-back runs with a single IDLE cycle.
      start = 1'b1;
      base  = cyc;
      push_op(base, NI, 16'hFFFF, 1'b1);
      push_op(base + 35, NI, 16'hFFFF, 1'b1);
      wait_cyc(base + 35);
      chk("b2b_idle_gap", {ready, ld_init}, 2'b10);
      wait_cyc(base + 36);
      chk("b2b_second_ld", {ready, ld_init}, 2'b01);
      start = 1'b0;
      drain("b2b_sb");

      // Vectoring: y_sign set only in SHX of iteration 3, flipped back in its SHY.
      z_sign = 1'b1;
      run_op(1'b1, NI, 16'h0008, 1'b1);
      wait_cyc(base + 8);
      y_sign = 1'b1;
      wait_cyc(base + 9);
      chk("vec_dir_shy3", {dir, shift_amt}, {1'b1, 4'd3});
      y_sign = 1'b0;
      wait_cyc(base + 10);
      chk("vec_dir_held", dir, 1'b1);
      drain("vec_sb");
      z_sign = 1'b0;

      // Abort in SHX of iteration 7, then a full run.
      d0 = done_cnt;
      run_op(1'b0, 7, 16'hFFFF, 1'b0);
      wait_cyc(base + 16);
      chk("abort_at_shx7", {tmp_en, shift_amt}, {1'b1, 4'd7});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {ready, xyz_en, done, ld_init}, 4'b1000);
      drain("abort_sb");
      chk("abort_no_done", done_cnt - d0, 0);
      run_op(1'b0, NI, 16'hFFFF, 1'b1);
      drain("after_abort_sb");
      chk("after_abort_done", done_cnt - d0, 1);

      // abort with start in IDLE keeps the sequencer idle.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_idle", {ready, ld_init}, 2'b10);
      drain("abort_start_sb");

      // Single-iteration instance driven from the vector table.
      for (int v = 0; v < 8; v++) begin
         mode   = tbl[v].m;
         z_sign = tbl[v].z;
         y_sign = tbl[v].y;
         start1 = 1'b1;
         base   = cyc;
         @(negedge clk);
         start1 = 1'b0;
         for (int k = 1; k <= 5; k++) begin
            wait_cyc(base + k);
            chk($sformatf("n1_v%0d_k%0d", v, k),
                {ready1, ld_init1, sh_sel1, tmp_en1, xyz_en1, done1, shift_amt1, atan_addr1},
                {seq1[k], 8'h00});
            if (k == 3) chk($sformatf("n1_v%0d_dir", v), dir1, tbl[v].d);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
